hdr_fetch: RTL and testbench
============================

HDR_FETCH -- requirements
Module: hdr_fetch

Interface
REQ-001 Parameter MASTER_ADDRESSWIDTH, default 26, master byte-address width.
REQ-002 Parameter DATAWIDTH, default 32, bus and stream data width.
REQ-003 Parameter MAXWORDS, default 20, max words per fetch (one 80-byte block header).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a fetch; sampled only in IDLE.
REQ-007 base_addr  input  MASTER_ADDRESSWIDTH  byte address of first word; bits [1:0] ignored (treated 0).
REQ-008 word_count  input  5  number of 32-bit words to fetch.
REQ-009 master_address  output  MASTER_ADDRESSWIDTH  Avalon-MM read address.
REQ-010 master_read  output  1  Avalon-MM read request.
REQ-011 master_readdata  input  DATAWIDTH  Avalon-MM read data.
REQ-012 master_readdatavalid  input  1  read data qualifier.
REQ-013 master_waitrequest  input  1  slave stall; request must be held while high.
REQ-014 out_data  output  DATAWIDTH  fetched word to hasher.
REQ-015 out_index  output  5  word index (0-based) of out_data.
REQ-016 out_valid  output  1  out_data/out_index valid.
REQ-017 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when fetch completes.

Function
REQ-020 FSM states: IDLE, REQ, WAIT_DATA, PUSH, DONE.
REQ-021 IDLE: start=1 latches base_addr (low 2 bits zeroed), effective count N = min(word_count, MAXWORDS), index=0; N>0 -> REQ, N=0 -> DONE.
REQ-022 start asserted outside IDLE is ignored.
REQ-023 REQ: master_read=1, master_address = base + 4*index; stay while master_waitrequest=1 with address held stable; -> WAIT_DATA on cycle where master_waitrequest=0.
REQ-024 Exactly one read outstanding; master_read=0 in all states except REQ.
REQ-025 WAIT_DATA: on master_readdatavalid=1 capture master_readdata into out_data, out_index=index -> PUSH; readdatavalid in any other state is ignored.
REQ-026 Readdatavalid in the same cycle the request is accepted (zero latency) is not supported; first valid data expected no earlier than the next cycle.
REQ-027 PUSH: out_valid=1, out_data/out_index stable until out_valid && out_ready; on handshake index increments; index+1 < N -> REQ, else -> DONE.
REQ-028 DONE: done=1 for exactly one cycle, busy=1, -> IDLE; start in the DONE cycle is ignored.
REQ-029 Address arithmetic wraps modulo 2^MASTER_ADDRESSWIDTH; no error flagged.
REQ-030 Minimum latency per word with waitrequest=0, readdatavalid one cycle after request, out_ready=1: 3 cycles (REQ, WAIT_DATA, PUSH).

Reset
REQ-031 reset_n=0 at any rising edge, including mid-fetch: state=IDLE, master_read=0, master_address=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0, internal index/count/base cleared.
REQ-032 Read data returning after a mid-fetch reset is ignored (state is IDLE).

Verification
REQ-033 base_addr=0x0800000, word_count=20, waitrequest=0, readdatavalid 1 cycle after request, out_ready=1 -> 20 reads at 0x0800000..0x080004C step 4, out_index 0..19 in order, done one pulse 60 cycles after start.
REQ-034 waitrequest held high 5 cycles on word 3 -> master_read and master_address (base+12) stable all 5 cycles, one read issued, no out_valid during stall.
REQ-035 out_ready low 4 cycles during PUSH of word 0 -> out_data/out_index stable, no new master_read until handshake.
REQ-036 word_count=0 -> no master_read, done pulse on cycle after start; word_count=31 -> exactly 20 reads.
REQ-037 reset_n low while in WAIT_DATA, readdatavalid arriving during reset and the cycle after -> all outputs 0, busy=0, no out_valid, no done.
REQ-038 start pulsed while busy and in DONE cycle -> ignored; start one cycle after done -> new fetch begins normally.

Source files
------------

// File: rtl/hdr_fetch.sv
// hdr_fetch: fetches up to MAXWORDS 32-bit words of a block header over an
// Avalon-MM read master (one read outstanding at a time) and streams each word
// with its index to the hasher through a valid/ready handshake.
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   start, base_addr, word_count
//                              fetch request (sampled in IDLE only)
//   master_address, master_read, master_readdata,
//   master_readdatavalid, master_waitrequest
//                              Avalon-MM read master
//   out_data, out_index, out_valid, out_ready
//                              word stream to hasher
//   busy, done                 status: busy outside IDLE, one-cycle done pulse
module hdr_fetch #(
  parameter int unsigned MASTER_ADDRESSWIDTH = 26,
  parameter int unsigned DATAWIDTH           = 32,
  parameter int unsigned MAXWORDS            = 20
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_addr,
  input  logic [4:0]                     word_count,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic [DATAWIDTH-1:0]           out_data,
  output logic [4:0]                     out_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned AW = MASTER_ADDRESSWIDTH;
  localparam int unsigned DW = DATAWIDTH;
  localparam int unsigned IW = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_PUSH      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] oidx_q, oidx_d;
  logic          read_q, read_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [IW-1:0] eff_cnt;
  logic [IW-1:0] idx_inc;
  logic [AW-1:0] base_aligned;

  // Requested length clamped to one header; base forced word-aligned.
  assign eff_cnt      = (word_count > IW'(MAXWORDS)) ? IW'(MAXWORDS) : word_count;
  assign idx_inc      = idx_q + IW'(1);
  assign base_aligned = base_addr & ~AW'(3);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oidx_d  = oidx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_aligned;
          cnt_d   = eff_cnt;
          idx_d   = '0;
          addr_d  = base_aligned;
          state_d = (eff_cnt != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (!master_waitrequest) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (master_readdatavalid) begin
          data_d  = master_readdata;
          oidx_d  = idx_q;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (out_ready) begin
          idx_d = idx_inc;
          if (idx_inc < cnt_q) begin
            // Address wraps naturally at AW bits.
            addr_d  = base_q + AW'({idx_inc, 2'b00});
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the decode of the next state.
    read_d  = (state_d == S_REQ);
    valid_d = (state_d == S_PUSH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      read_q  <= read_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign master_address = addr_q;
  assign master_read    = read_q;
  assign out_data       = data_q;
  assign out_index      = oidx_q;
  assign out_valid      = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_hdr_fetch.sv
// tb_hdr_fetch: directed bench for hdr_fetch with a one-cycle-latency memory
// responder, configurable waitrequest stall and out_ready back-pressure.
module tb_hdr_fetch;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [4:0]    word_count = '0;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic [DW-1:0] master_readdata = '0;
  logic          master_readdatavalid = 1'b0;
  logic          master_waitrequest = 1'b0;
  logic [DW-1:0] out_data;
  logic [4:0]    out_index;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  hdr_fetch dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .base_addr            (base_addr),
    .word_count           (word_count),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .out_data             (out_data),
    .out_index            (out_index),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents model: data word is a function of its byte address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ DW'(a);
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] b, input int n);
    return AW'(b + AW'(n * 4));
  endfunction

  // Bench model / responder state
  logic [AW-1:0] exp_base = '0;
  int            n_reads = 0;
  int            n_push = 0;
  int            n_done = 0;
  bit            pend = 1'b0;
  logic [DW-1:0] pend_data = '0;
  int            extra_rv = 0;
  logic [AW-1:0] stall_addr = '0;
  int            stall_left = 0;
  bit            stall_on = 1'b0;
  int            stall_cnt = 0;
  int            ready_hold = 0;
  int            hold_cnt = 0;

  // Responder and monitor: drives slave-side inputs and checks the stream.
  always @(negedge clk) begin
    if (extra_rv > 0) begin
      master_readdatavalid = 1'b1;
      master_readdata      = $urandom;
      extra_rv--;
    end else begin
      master_readdatavalid = pend;
      master_readdata      = pend ? pend_data : DW'($urandom);
    end

    if (stall_left > 0 && (stall_on || (master_read && master_address == stall_addr))) begin
      if (stall_on) begin
        chk("stall_read_held", master_read, 1);
        chk("stall_addr_held", master_address, stall_addr);
      end
      chk("stall_no_valid", out_valid, 0);
      stall_on           = 1'b1;
      master_waitrequest = 1'b1;
      stall_left--;
      stall_cnt++;
    end else begin
      stall_on           = 1'b0;
      master_waitrequest = 1'b0;
    end

    if (out_valid && ready_hold > 0) begin
      out_ready = 1'b0;
      ready_hold--;
      hold_cnt++;
      chk("hold_index", out_index, n_push);
      chk("hold_data", out_data, mem_word(word_addr(exp_base, n_push)));
    end else begin
      out_ready = 1'b1;
    end

    if (out_valid) chk("no_read_in_push", master_read, 0);

    if (master_read && !master_waitrequest) begin
      chk("read_addr", master_address, word_addr(exp_base, n_reads));
      n_reads++;
      pend      = 1'b1;
      pend_data = mem_word(master_address);
    end else begin
      pend = 1'b0;
    end

    if (out_valid && out_ready) begin
      chk("push_index", out_index, n_push);
      chk("push_data", out_data, mem_word(word_addr(exp_base, n_push)));
      n_push++;
    end

    if (done) n_done++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_read"}, master_read, 0);
    chk({tag, "_addr"}, master_address, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // One fetch; lat_exp counts cycles from the start edge to done visible.
  // poke re-asserts start while busy and in the DONE cycle.
  task automatic run_fetch(input logic [AW-1:0] base, input logic [4:0] wc,
                           input int n_exp, input int lat_exp, input bit poke);
    int cyc;
    bit seen;
    exp_base   = base & ~AW'(3);
    n_reads    = 0;
    n_push     = 0;
    n_done     = 0;
    base_addr  = base;
    word_count = wc;
    start      = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke && cyc == 2) begin
          start      = 1'b1;
          base_addr  = ~base;
          word_count = 5'd1;
        end
        tick;
        start = 1'b0;
        cyc++;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_latency", cyc, lat_exp);
    chk("busy_in_done", busy, 1);
    if (poke) start = 1'b1;
    tick;
    start = 1'b0;
    chk("done_one_pulse", done, 0);
    chk("idle_after_done", busy, 0);
    chk("read_count", n_reads, n_exp);
    chk("push_count", n_push, n_exp);
    chk("done_count", n_done, 1);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    tick;
    tick;
    chk_idle_zero("reset");
    reset_n = 1'b1;
    tick;

    // Full 20-word header at 3 cycles per word
    run_fetch(26'h0800000, 5'd20, 20, 60, 1'b0);

    // Waitrequest stall of 5 cycles on word 3
    stall_addr = 26'h000010C;
    stall_left = 5;
    stall_cnt  = 0;
    run_fetch(26'h0000100, 5'd6, 6, 23, 1'b0);
    chk("stall_cycles", stall_cnt, 5);

    // out_ready low for 4 cycles on word 0
    ready_hold = 4;
    hold_cnt   = 0;
    run_fetch(26'h0001000, 5'd3, 3, 13, 1'b0);
    chk("hold_cycles", hold_cnt, 4);

    // Zero words and over-long request
    run_fetch(26'h0002000, 5'd0, 0, 0, 1'b0);
    run_fetch(26'h0003000, 5'd31, 20, 60, 1'b0);

    // Unaligned base near the top of the address space wraps to 0
    run_fetch(26'h3FFFFFB, 5'd4, 4, 12, 1'b0);

    // Start pulses while busy and in DONE are ignored; next start works
    run_fetch(26'h0004000, 5'd2, 2, 6, 1'b1);
    run_fetch(26'h0005000, 5'd3, 3, 9, 1'b0);

    // Reset while waiting for data, with data returning during and after reset
    exp_base   = 26'h0006000;
    n_reads    = 0;
    n_push     = 0;
    base_addr  = 26'h0006000;
    word_count = 5'd5;
    start      = 1'b1;
    tick;
    start = 1'b0;
    guard = 0;
    while (!master_readdatavalid && guard < 50) begin
      tick;
      guard++;
    end
    chk("wait_data_reached", master_readdatavalid, 1);
    reset_n  = 1'b0;
    extra_rv = 1;
    n_done   = 0;
    tick;
    chk_idle_zero("midreset");
    reset_n = 1'b1;
    tick;
    chk_idle_zero("post_reset");
    tick;
    tick;
    chk("post_reset_no_done", n_done, 0);
    chk("post_reset_no_push", n_push, 0);

    // Recovery after reset
    run_fetch(26'h0007000, 5'd2, 2, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
